pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 id_rn  in  5  first source register of the instruction in ID.
REQ-005 id_rm  in  5  second source register of the instruction in ID.
REQ-006 id_uses_rm  in  1  ID instruction reads id_rm.
REQ-007 id_flag_branch  in  1  ID instruction is a flag-conditional branch (B.LT).
REQ-008 id_brtaken  in  1  branch resolved taken in ID.
REQ-009 ex_memread  in  1  EX instruction is a load.
REQ-010 ex_rd  in  5  EX destination register.
REQ-011 ex_setflag  in  1  EX instruction writes flags.
REQ-012 mem_access  in  1  MEM instruction is a load or store.
REQ-013 dmem_ready  in  1  data memory completes the MEM access this cycle.
REQ-014 pc_en, ifid_en, ex_en, mem_en, wb_en  out  1 each  stage register enables.
REQ-015 id_bubble  out  1  forces zero controls into ID/EX.
REQ-016 if_flush  out  1  clears IF/ID at next edge.
REQ-017 stall_count  out  16  count of cycles with pc_en=0.
REQ-018 mem_timeout  out  1  sticky data-memory timeout flag.

Function
REQ-019 FSM states: RUN, MEM_WAIT, FAULT; 4-bit wait_cnt.
REQ-020 Hazard H_lu: ex_memread=1, ex_rd!=31, and ex_rd==id_rn or (id_uses_rm=1 and ex_rd==id_rm).
REQ-021 Hazard H_fl: id_flag_branch=1 and ex_setflag=1.
REQ-022 Freeze F: (state==RUN and mem_access=1 and dmem_ready=0) or (state==MEM_WAIT and dmem_ready=0).
REQ-023 Priority: FAULT > F > (H_lu or H_fl) > id_brtaken > normal.
REQ-024 Normal: all enables 1, id_bubble=0, if_flush=0.
REQ-025 F: all enables 0, id_bubble=0, if_flush=0.
REQ-026 H_lu or H_fl without F: pc_en=0, ifid_en=0, ex_en=mem_en=wb_en=1, id_bubble=1, if_flush=0 (branch in ID stays held).
REQ-027 id_brtaken alone: all enables 1, if_flush=1.
REQ-028 RUN->MEM_WAIT when mem_access=1 and dmem_ready=0; wait_cnt loads 1.
REQ-029 MEM_WAIT with dmem_ready=1: outputs per normal rules that cycle; ->RUN; wait_cnt clears to 0.
REQ-030 MEM_WAIT with dmem_ready=0 and wait_cnt<15: wait_cnt increments.
REQ-031 MEM_WAIT with dmem_ready=0 and wait_cnt==15: ->FAULT; mem_timeout sets to 1.
REQ-032 FAULT: all enables 0, id_bubble=0, if_flush=0; exits only on reset.
REQ-033 stall_count increments each cycle pc_en=0, including FAULT; saturates at 16'hFFFF.
REQ-034 Register 31 never creates a hazard.

Reset
REQ-035 While reset_n=0: state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0.
REQ-036 While reset_n=0: all enables 0, id_bubble=0, if_flush=0, regardless of inputs.
REQ-037 Reset asserted in MEM_WAIT or FAULT returns to RUN immediately; first edge after release operates from RUN.

Verification
REQ-038 Load-use: ex_memread=1, ex_rd=3, id_rn=3 for 1 cycle -> pc_en=0, ifid_en=0, id_bubble=1; next cycle with ex_memread=0 -> normal; stall_count=1.
REQ-039 X31 check: ex_memread=1, ex_rd=31, id_rn=31 -> no stall, id_bubble=0.
REQ-040 Flag hazard plus branch: id_flag_branch=1, ex_setflag=1, id_brtaken=1 -> bubble, if_flush=0; next cycle with ex_setflag=0 -> if_flush=1.
REQ-041 Memory wait: mem_access=1, dmem_ready=0 for 3 cycles, then dmem_ready=1 -> all enables 0 for 3 cycles, 1 on the 4th; state RUN; stall_count=3.
REQ-042 Timeout: dmem_ready held 0 -> mem_timeout=1 after 16 frozen cycles; enables stay 0; reset_n pulse clears mem_timeout and stall_count.
REQ-043 Saturation: hold FAULT for 70000 cycles -> stall_count=16'hFFFF.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Pipeline stall/flush sequencer: load-use and flag hazards, taken-branch flush, data-memory freeze with timeout.
// Enables and bubble/flush respond combinationally in the same cycle; FSM, stall counter and timeout flag are registered.
module pipeline_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic        id_uses_rm,
    input  logic        id_flag_branch,
    input  logic        id_brtaken,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_setflag,
    input  logic        mem_access,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ex_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        id_bubble,
    output logic        if_flush,
    output logic [15:0] stall_count,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic h_lu, h_fl, freeze;

    always_comb begin
        // X31 is the zero register, so it can never carry a real dependency
        h_lu   = ex_memread && (ex_rd != 5'd31) &&
                 ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
        h_fl   = id_flag_branch && ex_setflag;
        freeze = !dmem_ready && (((state_q == RUN) && mem_access) || (state_q == MEM_WAIT));
    end

    always_comb begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        ex_en     = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;
        id_bubble = 1'b0;
        if_flush  = 1'b0;
        if (reset_n && (state_q != FAULT) && !freeze) begin
            ex_en  = 1'b1;
            mem_en = 1'b1;
            wb_en  = 1'b1;
            if (h_lu || h_fl) begin
                id_bubble = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                if_flush = id_brtaken;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        stall_count_d = stall_count_q;
        if (!pc_en && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        case (state_q)
            RUN: begin
                if (mem_access && !dmem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 4'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 4'd0;
                end else if (wait_cnt_q == 4'd15) begin
                    state_d       = FAULT;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= 4'd0;
            stall_count_q <= 16'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign stall_count = stall_count_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized and directed bench for pipeline_sequencer against a behavioural model of the stall/flush rules.
module tb_pipeline_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rn, id_rm, ex_rd;
    logic        id_uses_rm, id_flag_branch, id_brtaken;
    logic        ex_memread, ex_setflag, mem_access, dmem_ready;
    logic        pc_en, ifid_en, ex_en, mem_en, wb_en, id_bubble, if_flush;
    logic [15:0] stall_count;
    logic        mem_timeout;

    int checks = 0;
    int errors = 0;

    // model: consecutive frozen cycles, fault latch, stall total, timeout flag
    int m_frozen;
    bit m_fault;
    int m_stall;
    bit m_timeout;

    wire [6:0] outs = {pc_en, ifid_en, ex_en, mem_en, wb_en, id_bubble, if_flush};

    localparam logic [6:0] O_NORM   = 7'b1111100;
    localparam logic [6:0] O_FLUSH  = 7'b1111101;
    localparam logic [6:0] O_BUBBLE = 7'b0011110;
    localparam logic [6:0] O_STOP   = 7'b0000000;

    always #5 clk = ~clk;

    pipeline_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .id_flag_branch(id_flag_branch), .id_brtaken(id_brtaken),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_setflag(ex_setflag),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
        .id_bubble(id_bubble), .if_flush(if_flush),
        .stall_count(stall_count), .mem_timeout(mem_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_freeze();
        return !dmem_ready && (m_frozen > 0 || mem_access);
    endfunction

    function automatic logic [6:0] model_outs();
        bit hz;
        if (!reset_n || m_fault || model_freeze()) return O_STOP;
        hz = (ex_memread && ex_rd != 31 &&
              (ex_rd == id_rn || (id_uses_rm && ex_rd == id_rm))) ||
             (id_flag_branch && ex_setflag);
        if (hz) return O_BUBBLE;
        return id_brtaken ? O_FLUSH : O_NORM;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_frozen = 0; m_fault = 0; m_stall = 0; m_timeout = 0;
        end else begin
            if (model_outs() == O_STOP || model_outs() == O_BUBBLE)
                m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
            if (!m_fault) begin
                if (model_freeze()) begin
                    m_frozen++;
                    if (m_frozen == 16) begin m_fault = 1; m_timeout = 1; end
                end else begin
                    m_frozen = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("outs", {25'd0, outs}, {25'd0, model_outs()});
        check("stall_count", {16'd0, stall_count}, m_stall);
        check("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_timeout});
    end

    task automatic set_in(input logic [4:0] rn, input logic [4:0] rm, input logic urm,
                          input logic fb, input logic bt, input logic mr, input logic [4:0] rd,
                          input logic sf, input logic ma, input logic dr);
        id_rn = rn; id_rm = rm; id_uses_rm = urm; id_flag_branch = fb; id_brtaken = bt;
        ex_memread = mr; ex_rd = rd; ex_setflag = sf; mem_access = ma; dmem_ready = dr;
    endtask

    task automatic quiet();
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
    endtask

    function automatic logic [4:0] rand_reg();
        int r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        reset_n = 1'b0;
        // hazard and freeze inputs active during reset must not leak to outputs
        set_in(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("reset_outs", {25'd0, outs}, {25'd0, O_STOP});
        check("reset_stall", {16'd0, stall_count}, 32'd0);
        next_cycle(); next_cycle();
        quiet();
        reset_n = 1'b1;

        set_in(5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("loaduse_outs", {25'd0, outs}, {25'd0, O_BUBBLE});
        next_cycle();
        quiet();
        @(negedge clk);
        check("loaduse_after", {25'd0, outs}, {25'd0, O_NORM});
        check("loaduse_stall", {16'd0, stall_count}, 32'd1);
        next_cycle();

        set_in(5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("x31_outs", {25'd0, outs}, {25'd0, O_NORM});
        next_cycle();

        set_in(5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("flag_bubble", {25'd0, outs}, {25'd0, O_BUBBLE});
        next_cycle();
        set_in(5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("flag_flush", {25'd0, outs}, {25'd0, O_FLUSH});
        next_cycle();

        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            check("memwait_frozen", {25'd0, outs}, {25'd0, O_STOP});
            next_cycle();
        end
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("memwait_release", {25'd0, outs}, {25'd0, O_NORM});
        check("memwait_stall", {16'd0, stall_count}, 32'd3);
        next_cycle();
        quiet();
        @(negedge clk);
        check("memwait_run", {25'd0, outs}, {25'd0, O_NORM});
        next_cycle();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                set_in(rand_reg(), rand_reg(), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), rand_reg(), 1'($urandom),
                       1'($urandom), ($urandom_range(0, 9) < 7));
                next_cycle();
            end
        end

        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            if (i == 15) check("timeout_not_yet", {31'd0, mem_timeout}, 32'd0);
            next_cycle();
        end
        quiet();
        @(negedge clk);
        check("timeout_set", {31'd0, mem_timeout}, 32'd1);
        check("fault_outs", {25'd0, outs}, {25'd0, O_STOP});
        check("fault_stall", {16'd0, stall_count}, 32'd16);
        next_cycle();

        for (int i = 0; i < 70000; i++) begin
            set_in(rand_reg(), rand_reg(), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), rand_reg(), 1'($urandom), 1'($urandom), 1'($urandom));
            next_cycle();
        end
        @(negedge clk);
        check("saturate", {16'd0, stall_count}, 32'h0000FFFF);
        next_cycle();

        do_reset();
        quiet();
        @(negedge clk);
        check("post_reset_timeout", {31'd0, mem_timeout}, 32'd0);
        check("post_reset_outs", {25'd0, outs}, {25'd0, O_NORM});
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
